apb_mm_arbiter: RTL and testbench
=================================

# apb_mm_arbiter

Round-robin APB master arbiter that shares the matrix-multiplier accelerator's APB slave port among `N_REQ` requesters, for example the host bridge and a DMA/loader engine. Each requester issues single-beat read or write transactions. The block serialises them into legal APB setup/access phases, honours the accelerator's `busy` flag, and bounds every access with a timeout. It sits between the requester fabric and the accelerator's `psel/penable/...` port.

## Interface
**Parameters**
- `BW`, default 64: APB data width.
- `DW`, default 16: element width; `MAX_DIM = BW/DW` is the strobe width.
- `ADDR_W`, default 32: APB address width.
- `N_REQ`, default 2: number of requesters, ≥1.
- `TIMEOUT`, default 255: maximum ACCESS cycles before abort, ≥1.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in N_REQ: per-requester request.
- `req_ready_o` out N_REQ: one-hot grant; the request is accepted when valid&ready.
- `req_write_i` in N_REQ: 1 = write.
- `req_addr_i` in N_REQ×ADDR_W: request address.
- `req_wdata_i` in N_REQ×BW: write data.
- `req_strb_i` in N_REQ×MAX_DIM: write strobes.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_id_o` out $clog2(N_REQ) (min 1): index of the requester being answered.
- `rsp_rdata_o` out BW: read data; 0 on writes and on timeout.
- `rsp_err_o` out 1: `pslverr` or timeout.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB controls.
- `paddr_o` out ADDR_W, `pwdata_o` out BW, `pstrb_o` out MAX_DIM: APB payload.
- `prdata_i` in BW, `pready_i` in 1, `pslverr_i` in 1: APB slave response.
- `busy_i` in 1: accelerator computing.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - A requester is eligible when `req_valid_i[k]` is high and (`!req_write_i[k]` or `!busy_i`). Writes are never issued while the accelerator is busy; reads always may be.
  - The eligible requester at or after `rr_ptr` (ascending, wrapping) wins. `req_ready_o[k]` is driven high combinationally in that cycle only.
  - On the grant: latch write/addr/wdata/strb/id, set `rr_ptr = (k+1) mod N_REQ`, and go to SETUP.
  - With no eligible requester, stay in IDLE. A blocked writer does not block readers.
- **SETUP:** `psel_o=1`, `penable_o=0`, payload driven from the latch. Always go to ACCESS.
- **ACCESS:**
  - `psel_o=1`, `penable_o=1`, and the timeout counter increments.
  - If `pready_i` is high: capture `prdata_i` (reads only) and `pslverr_i`, then go to RESP.
  - Else, if the counter has reached `TIMEOUT`: `err=1`, `rdata=0`, go to RESP.
- **RESP:**
  - `psel_o=0`, `penable_o=0`.
  - `rsp_valid_o=1` with the captured id/rdata/err.
  - Always go to IDLE.
- **Payload stability:** the payload is stable from SETUP through the last ACCESS cycle. `pwdata_o` and `pstrb_o` are 0 on reads.
- **busy_i timing:** `busy_i` is sampled only in IDLE. A change of `busy_i` during SETUP or ACCESS does not affect the transfer in flight.

## Timing
- **Grant to response:** a grant in cycle t gives `psel_o` at t+1, `penable_o` at t+2, and, with `pready_i` at t+2, `rsp_valid_o` at t+3. The next grant is possible at t+4. Minimum period is 4 cycles per transfer.
- **Wait states:** each cycle of `pready_i` low in ACCESS adds one cycle.
- **Timeout:** fires after `TIMEOUT` ACCESS cycles without `pready_i`, and the response follows the next cycle.
- **Registered outputs:** all APB outputs and `rsp_*` are registered. `req_ready_o` is combinational from the state, the inputs and `rr_ptr`.
- **Reset values:**
  - state = IDLE, `rr_ptr` = 0, timeout counter = 0.
  - `psel_o`, `penable_o`, `pwrite_o` = 0; `paddr_o`, `pwdata_o`, `pstrb_o` = 0.
  - `rsp_valid_o`, `rsp_err_o` = 0; `rsp_rdata_o`, `rsp_id_o` = 0.
  - `req_ready_o` is forced to 0 while `rst` is high.
- **Reset mid-transfer:** the transfer is dropped, no response is emitted, and the APB outputs are deasserted on the next edge.
- **Simultaneous requests:** exactly one grant per IDLE cycle. Fairness holds: with all requesters valid continuously, grants follow 0,1,…,N_REQ−1,0.

## Structure
- **Package `apb_mm_arb_pkg`:**
  - `state_t` enum {IDLE, SETUP, ACCESS, RESP}.
  - A default `TIMEOUT` constant.
  - Function `idw(N)` returning the id width.
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs are the eligible vector and `rr_ptr`; outputs are a one-hot grant, an index and a `found` flag.
- **Top level:** instantiates `rr_pick` once, together with the FSM, the latch and the timeout counter.

## Test plan
- **Basic write and read:** requester 0 writes addr 0x10, data 0x0004_0003_0002_0001, strb 0xF, with `pready` tied high. Required: `psel` at t+1, `penable` at t+2, `rsp_valid` at t+3 with err=0 and rdata=0. A read of 0x10 with `prdata`=0xDEAD returns 0xDEAD.
- **Round-robin fairness:** N_REQ=2, both requesters valid continuously. Required grant order 0,1,0,1, with a grant every 4 cycles.
- **Busy gating:** `busy_i`=1; requester 0 presents a write and requester 1 a read. Requester 1 is granted and requester 0 waits. Requester 0 is granted in the first IDLE cycle after `busy_i` drops.
- **Wait states and slave error:** `pready_i` low for 3 ACCESS cycles, then high with `pslverr_i`=1. Required: `penable` stays high for 4 cycles, `rsp_err_o`=1, and the payload is unchanged throughout.
- **Timeout:** with TIMEOUT=4 and `pready_i` never asserted, required: 4 ACCESS cycles, then `rsp_valid_o` with err=1 and rdata=0, then a return to IDLE.
- **Reset mid-transfer:** assert `rst` during ACCESS. Required: `psel`/`penable` are 0 on the next edge, no `rsp_valid_o` is produced, and the next grant goes to requester 0.

Source files
------------

// File: rtl/apb_mm_arbiter_pkg.sv
// Shared types and helpers for the round-robin APB arbiter in front of the
// matrix-multiplier accelerator.
package apb_mm_arb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam int DEFAULT_TIMEOUT = 255;

   // Width of a requester index; never narrower than one bit.
   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_mm_arbiter_rr_pick.sv
// Combinational round-robin picker: the lowest eligible index at or after ptr
// wins, wrapping to the lowest eligible index below ptr.
module rr_pick
   import apb_mm_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]      eligible,
   input  logic [idw(N)-1:0] ptr,
   output logic [N-1:0]      grant,
   output logic [idw(N)-1:0] idx,
   output logic              found
);

   localparam int IW = idw(N);

   // The second pass overrides the first, so indices at/after ptr take priority.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i] && (i < int'(ptr))) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IW'(i);
            found    = 1'b1;
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i] && (i >= int'(ptr))) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IW'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_mm_arbiter.sv
// Round-robin arbiter serialising single-beat requests from N_REQ requesters
// onto the accelerator's APB slave port, with busy gating and an access timeout.
module apb_mm_arbiter
   import apb_mm_arb_pkg::*;
#(
   parameter int BW      = 64,
   parameter int DW      = 16,
   parameter int ADDR_W  = 32,
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid_i,
   output logic [N_REQ-1:0]            req_ready_o,
   input  logic [N_REQ-1:0]            req_write_i,
   input  logic [N_REQ*ADDR_W-1:0]     req_addr_i,
   input  logic [N_REQ*BW-1:0]         req_wdata_i,
   input  logic [N_REQ*(BW/DW)-1:0]    req_strb_i,
   output logic                        rsp_valid_o,
   output logic [idw(N_REQ)-1:0]       rsp_id_o,
   output logic [BW-1:0]               rsp_rdata_o,
   output logic                        rsp_err_o,
   output logic                        psel_o,
   output logic                        penable_o,
   output logic                        pwrite_o,
   output logic [ADDR_W-1:0]           paddr_o,
   output logic [BW-1:0]               pwdata_o,
   output logic [(BW/DW)-1:0]          pstrb_o,
   input  logic [BW-1:0]               prdata_i,
   input  logic                        pready_i,
   input  logic                        pslverr_i,
   input  logic                        busy_i
);

   localparam int MAX_DIM = BW / DW;
   localparam int IW      = idw(N_REQ);
   localparam int TW      = $clog2(TIMEOUT + 1);

   state_t           state, nstate;
   logic [IW-1:0]    rr_ptr, pick_idx, lat_id;
   logic [TW-1:0]    cnt;
   logic [N_REQ-1:0] eligible, pick_grant;
   logic             found, grant_now, timed_out, access_done;

   // Writes wait while the accelerator computes; reads are always allowed.
   assign eligible = req_valid_i & (~req_write_i | {N_REQ{~busy_i}});

   rr_pick #(.N(N_REQ)) u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .grant    (pick_grant),
      .idx      (pick_idx),
      .found    (found)
   );

   assign grant_now   = (state == IDLE) && found && !rst;
   assign req_ready_o = grant_now ? pick_grant : '0;
   assign timed_out   = (cnt == TW'(TIMEOUT - 1));
   assign access_done = (state == ACCESS) && (pready_i || timed_out);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (found) nstate = SETUP;
         SETUP:   nstate = ACCESS;
         ACCESS:  if (pready_i || timed_out) nstate = RESP;
         RESP:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr      <= '0;
         cnt         <= '0;
         lat_id      <= '0;
         psel_o      <= 1'b0;
         penable_o   <= 1'b0;
         pwrite_o    <= 1'b0;
         paddr_o     <= '0;
         pwdata_o    <= '0;
         pstrb_o     <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_id_o    <= '0;
      end else begin
         psel_o      <= (nstate == SETUP) || (nstate == ACCESS);
         penable_o   <= (nstate == ACCESS);
         rsp_valid_o <= (nstate == RESP);
         cnt         <= (state == ACCESS) ? cnt + 1'b1 : '0;
         if (grant_now) begin
            rr_ptr   <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
            lat_id   <= pick_idx;
            pwrite_o <= req_write_i[pick_idx];
            paddr_o  <= req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
            pwdata_o <= req_write_i[pick_idx] ? req_wdata_i[int'(pick_idx)*BW +: BW] : '0;
            pstrb_o  <= req_write_i[pick_idx] ? req_strb_i[int'(pick_idx)*MAX_DIM +: MAX_DIM] : '0;
         end
         if (access_done) begin
            rsp_id_o    <= lat_id;
            rsp_err_o   <= pready_i ? pslverr_i : 1'b1;
            rsp_rdata_o <= (pready_i && !pwrite_o) ? prdata_i : '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_mm_arbiter.sv
// Testbench for apb_mm_arbiter: directed scenarios plus a randomized run
// against a transaction-level timing model.
`timescale 1ns/1ps
module tb_apb_mm_arbiter;

   localparam int N  = 2;
   localparam int BW = 64;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int MD = BW / DW;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid, req_ready, req_write;
   logic [AW-1:0] a_addr  [N];
   logic [BW-1:0] a_wdata [N];
   logic [MD-1:0] a_strb  [N];
   logic [N*AW-1:0] req_addr;
   logic [N*BW-1:0] req_wdata;
   logic [N*MD-1:0] req_strb;
   logic          rsp_valid, rsp_err;
   logic [0:0]    rsp_id;
   logic [BW-1:0] rsp_rdata, pwdata, prdata;
   logic          psel, penable, pwrite, pready, pslverr, busy;
   logic [AW-1:0] paddr;
   logic [MD-1:0] pstrb;

   int checks   = 0;
   int failures = 0;

   assign req_addr  = {a_addr[1], a_addr[0]};
   assign req_wdata = {a_wdata[1], a_wdata[0]};
   assign req_strb  = {a_strb[1], a_strb[0]};

   apb_mm_arbiter #(.BW(BW), .DW(DW), .ADDR_W(AW), .N_REQ(N), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_strb_i  (req_strb),
      .rsp_valid_o (rsp_valid),
      .rsp_id_o    (rsp_id),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .psel_o      (psel),
      .penable_o   (penable),
      .pwrite_o    (pwrite),
      .paddr_o     (paddr),
      .pwdata_o    (pwdata),
      .pstrb_o     (pstrb),
      .prdata_i    (prdata),
      .pready_i    (pready),
      .pslverr_i   (pslverr),
      .busy_i      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid = '0;
      req_write = '0;
      for (int k = 0; k < N; k++) begin
         a_addr[k]  = '0;
         a_wdata[k] = '0;
         a_strb[k]  = '0;
      end
      prdata  = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      busy    = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      req_valid = 2'b11;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
         failures++; $display("FAIL reset_ready got=%b exp=00", req_ready);
      end
      checks++;
      if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=00000", {psel, penable, pwrite, rsp_valid, rsp_err});
      end
      checks++;
      if ({paddr, pwdata, pstrb, rsp_rdata, rsp_id} !== '0) begin
         failures++; $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h id=%0d exp=0", paddr, pwdata, pstrb, rsp_rdata, rsp_id);
      end
      tick();
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_basic();
      do_reset();
      pready       = 1'b1;
      req_valid    = 2'b01;
      req_write    = 2'b01;
      a_addr[0]    = 32'h10;
      a_wdata[0]   = 64'h0004_0003_0002_0001;
      a_strb[0]    = 4'hF;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin failures++; $display("FAIL basic_wr_grant got=%b exp=01", req_ready); end
      tick();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if ({psel, penable} !== 2'b10) begin failures++; $display("FAIL basic_wr_setup got=%b exp=10", {psel, penable}); end
      checks++;
      if ({pwrite, paddr, pwdata, pstrb} !== {1'b1, 32'h10, 64'h0004_0003_0002_0001, 4'hF}) begin
         failures++; $display("FAIL basic_wr_payload got w=%b a=%h d=%h s=%h", pwrite, paddr, pwdata, pstrb);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL basic_wr_access got=%b exp=11", {psel, penable}); end
      tick();
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, psel, penable, rsp_id, rsp_rdata} !== {4'b1000, 1'b0, 64'h0}) begin
         failures++; $display("FAIL basic_wr_rsp got v=%b e=%b sel=%b en=%b id=%0d rd=%h", rsp_valid, rsp_err, psel, penable, rsp_id, rsp_rdata);
      end
      tick();
      req_valid = 2'b01;
      req_write = 2'b00;
      prdata    = 64'hDEAD;
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready} !== 3'b001) begin failures++; $display("FAIL basic_rd_grant got v=%b rdy=%b exp v=0 rdy=01", rsp_valid, req_ready); end
      tick();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if ({psel, pwrite, paddr, pwdata, pstrb} !== {2'b10, 32'h10, 64'h0, 4'h0}) begin
         failures++; $display("FAIL basic_rd_setup got sel=%b w=%b a=%h d=%h s=%h", psel, pwrite, paddr, pwdata, pstrb);
      end
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 64'hDEAD}) begin
         failures++; $display("FAIL basic_rd_rsp got v=%b e=%b rd=%h exp rd=dead", rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp_r;
      clear_inputs();
      rst       = 1'b1;
      req_valid = 2'b11;
      pready    = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) tick();
         @(negedge clk);
         exp_r = (c % 4 != 0) ? 2'b00 : (((c / 4) % 2) == 1 ? 2'b10 : 2'b01);
         checks++;
         if (req_ready !== exp_r) begin failures++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, exp_r); end
         if (c % 4 == 3) begin
            checks++;
            if ({rsp_valid, rsp_id} !== {1'b1, 1'(((c / 4) % 2))}) begin
               failures++; $display("FAIL fair_rsp c=%0d got v=%b id=%0d", c, rsp_valid, rsp_id);
            end
         end
      end
   endtask

   task automatic test_busy();
      logic [N-1:0] exp_r;
      do_reset();
      busy      = 1'b1;
      pready    = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b01;
      for (int c = 0; c <= 6; c++) begin
         if (c > 0) tick();
         if (c == 1) req_valid[1] = 1'b0;
         if (c == 6) busy = 1'b0;
         @(negedge clk);
         exp_r = (c == 0) ? 2'b10 : ((c == 6) ? 2'b01 : 2'b00);
         checks++;
         if (req_ready !== exp_r) begin failures++; $display("FAIL busy_grant c=%0d got=%b exp=%b", c, req_ready, exp_r); end
         if (c == 3) begin
            checks++;
            if ({rsp_valid, rsp_id} !== 2'b11) begin failures++; $display("FAIL busy_rsp got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); end
         end
      end
   endtask

   task automatic test_wait_err();
      logic [AW-1:0] ad;
      logic [BW-1:0] wd;
      logic [MD-1:0] st;
      do_reset();
      ad = $urandom;
      wd = {$urandom, $urandom};
      st = MD'($urandom);
      req_valid  = 2'b10;
      req_write  = 2'b10;
      a_addr[1]  = ad;
      a_wdata[1] = wd;
      a_strb[1]  = st;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         if (c == 1) begin
            req_valid  = '0;
            a_addr[1]  = ~ad;
            a_wdata[1] = ~wd;
            a_strb[1]  = ~st;
            busy       = 1'b1;
         end
         pready  = (c == 5);
         pslverr = (c == 5);
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (req_ready !== 2'b10) begin failures++; $display("FAIL wait_grant got=%b exp=10", req_ready); end
         end
         checks++;
         if ({psel, penable} !== {(c >= 1 && c <= 5), (c >= 2 && c <= 5)}) begin
            failures++; $display("FAIL wait_ctrl c=%0d got sel=%b en=%b", c, psel, penable);
         end
         if (c >= 1 && c <= 5) begin
            checks++;
            if ({pwrite, paddr, pwdata, pstrb} !== {1'b1, ad, wd, st}) begin
               failures++; $display("FAIL wait_payload c=%0d got a=%h d=%h s=%h exp a=%h d=%h s=%h", c, paddr, pwdata, pstrb, ad, wd, st);
            end
         end
         if (c == 6) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_id, rsp_rdata} !== {3'b111, 64'h0}) begin
               failures++; $display("FAIL wait_rsp got v=%b e=%b id=%0d rd=%h", rsp_valid, rsp_err, rsp_id, rsp_rdata);
            end
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req_valid = 2'b01;
      a_addr[0] = $urandom;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) tick();
         if (c == 1) req_valid = '0;
         if (c == 7) req_valid = 2'b10;
         prdata  = {$urandom, $urandom};
         pslverr = 1'($urandom_range(0, 1));
         @(negedge clk);
         checks++;
         if ({psel, penable} !== {(c >= 1 && c <= 5), (c >= 2 && c <= 5)}) begin
            failures++; $display("FAIL tmo_ctrl c=%0d got sel=%b en=%b", c, psel, penable);
         end
         if (c == 6) begin
            checks++;
            if ({rsp_valid, rsp_err, rsp_id, rsp_rdata} !== {3'b110, 64'h0}) begin
               failures++; $display("FAIL tmo_rsp got v=%b e=%b id=%0d rd=%h", rsp_valid, rsp_err, rsp_id, rsp_rdata);
            end
         end
         if (c == 7) begin
            checks++;
            if ({rsp_valid, req_ready} !== 3'b010) begin
               failures++; $display("FAIL tmo_idle got v=%b rdy=%b exp v=0 rdy=10", rsp_valid, req_ready);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 2'b01;
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) tick();
         if (c == 1) req_valid = '0;
         if (c == 2) rst = 1'b1;
         if (c == 3) begin
            rst       = 1'b0;
            req_valid = 2'b11;
         end
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rstmid_access got=%b exp=11", {psel, penable}); end
         end
         if (c == 3) begin
            checks++;
            if ({psel, penable, rsp_valid, req_ready} !== 5'b00001) begin
               failures++; $display("FAIL rstmid_after got sel=%b en=%b v=%b rdy=%b exp 0 0 0 01", psel, penable, rsp_valid, req_ready);
            end
         end
         if (c == 4) begin
            checks++;
            if ({rsp_valid, psel} !== 2'b01) begin failures++; $display("FAIL rstmid_next got v=%b sel=%b exp v=0 sel=1", rsp_valid, psel); end
         end
      end
   endtask

   task automatic test_random();
      bit            pend [N];
      bit            pw   [N];
      logic [AW-1:0] pa   [N];
      logic [BW-1:0] pd   [N];
      logic [MD-1:0] ps   [N];
      int            ptr, free_at, g, len, waits, tid, k;
      bit            twr, terr, e_sel, e_en, e_rsp;
      logic [AW-1:0] taddr;
      logic [BW-1:0] twd, trd, e_wd;
      logic [MD-1:0] tst, e_st;
      logic [N-1:0]  e_rdy;
      ptr = 0; free_at = 0; g = -100; len = 0; waits = 0; tid = 0;
      twr = 0; terr = 0; taddr = '0; twd = '0; trd = '0; tst = '0;
      for (int j = 0; j < N; j++) begin
         pend[j] = 0; pw[j] = 0; pa[j] = '0; pd[j] = '0; ps[j] = '0;
      end
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc > 0) tick();
         for (int j = 0; j < N; j++) begin
            if (!pend[j] && $urandom_range(0, 2) == 0) begin
               pend[j] = 1;
               pw[j]   = 1'($urandom_range(0, 1));
               pa[j]   = $urandom;
               pd[j]   = {$urandom, $urandom};
               ps[j]   = MD'($urandom);
            end
            req_valid[j] = pend[j];
            req_write[j] = pw[j];
            a_addr[j]    = pa[j];
            a_wdata[j]   = pd[j];
            a_strb[j]    = ps[j];
         end
         busy    = ($urandom_range(0, 3) == 0);
         prdata  = {$urandom, $urandom};
         pslverr = 1'($urandom_range(0, 1));
         if (cyc >= g + 2 && cyc <= g + 1 + len) begin
            pready = (waits < TO) && (cyc == g + 2 + waits);
            if (pready) begin
               trd  = twr ? '0 : prdata;
               terr = pslverr;
            end
         end else begin
            pready = 1'($urandom_range(0, 1));
         end
         e_rdy = '0;
         if (cyc >= free_at) begin
            for (int i = 0; i < N; i++) begin
               k = (ptr + i) % N;
               if (e_rdy == '0 && pend[k] && (!pw[k] || !busy)) e_rdy[k] = 1'b1;
            end
         end
         e_sel = (cyc >= g + 1) && (cyc <= g + 1 + len);
         e_en  = (cyc >= g + 2) && (cyc <= g + 1 + len);
         e_rsp = (cyc == g + 2 + len);
         e_wd  = twr ? twd : '0;
         e_st  = twr ? tst : '0;
         @(negedge clk);
         checks++;
         if (req_ready !== e_rdy) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy); end
         checks++;
         if ({psel, penable} !== {e_sel, e_en}) begin
            failures++; $display("FAIL rnd_ctrl cyc=%0d got sel=%b en=%b exp sel=%b en=%b", cyc, psel, penable, e_sel, e_en);
         end
         if (e_sel) begin
            checks++;
            if ({pwrite, paddr, pwdata, pstrb} !== {twr, taddr, e_wd, e_st}) begin
               failures++; $display("FAIL rnd_payload cyc=%0d got w=%b a=%h d=%h s=%h exp w=%b a=%h d=%h s=%h", cyc, pwrite, paddr, pwdata, pstrb, twr, taddr, e_wd, e_st);
            end
         end
         checks++;
         if (rsp_valid !== e_rsp) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rsp); end
         if (e_rsp) begin
            checks++;
            if ({rsp_id, rsp_err, rsp_rdata} !== {1'(tid), terr, trd}) begin
               failures++; $display("FAIL rnd_rsp_data cyc=%0d got id=%0d e=%b rd=%h exp id=%0d e=%b rd=%h", cyc, rsp_id, rsp_err, rsp_rdata, tid, terr, trd);
            end
         end
         if (e_rdy != '0) begin
            for (int j = 0; j < N; j++) begin
               if (e_rdy[j]) begin
                  tid = j; twr = pw[j]; taddr = pa[j]; twd = pd[j]; tst = ps[j];
                  pend[j] = 0;
                  ptr = (j + 1) % N;
               end
            end
            g     = cyc;
            waits = $urandom_range(0, 5);
            len   = (waits >= TO) ? TO : waits + 1;
            if (waits >= TO) begin
               trd  = '0;
               terr = 1'b1;
            end
            free_at = cyc + 3 + len;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fairness();
      test_busy();
      test_wait_err();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
